// File: rtl/priority_encoder_q_pkg.sv
// Shared definitions for the priority encoder queue: FSM state and
// arbitration mode selectors.
package enc_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

endpackage

// File: rtl/pri_find_first.sv
// Combinational circular search: returns the first set bit of vec at or
// above start, wrapping to the lowest set bit when nothing is set above.
module pri_find_first #(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] idx
);

  logic [N-1:0] upper_mask;
  logic [N-1:0] upper_vec;
  logic [N-1:0] search_vec;

  // Mark positions at or above the start index.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_mask
      assign upper_mask[gi] = (W'(gi) >= start);
    end
  endgenerate

  assign upper_vec  = vec & upper_mask;
  // Prefer the upper segment; fall back to the whole vector for the wrap.
  assign search_vec = (|upper_vec) ? upper_vec : vec;

  // Lowest set bit of the chosen segment.
  always_comb begin
    found = |vec;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (search_vec[i]) begin
        idx = W'(i);
      end
    end
  end

endmodule

// File: rtl/priority_encoder_q.sv
// Pending-request register with a two-state grant FSM. Requests accumulate
// in pending; one is presented at a time on out_index with a valid/ready
// handshake. Fixed-priority or round-robin selection by parameter.
module priority_encoder_q
  import enc_pkg::*;
#(
  parameter int N  = 16,
  parameter int W  = $clog2(N),
  parameter int RR = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic [N-1:0] req_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_index,
  output logic [N-1:0] pending,
  output logic         drop
);

  state_t       state_reg;
  logic         out_valid_reg;
  logic [W-1:0] out_index_reg;
  logic [W-1:0] ptr_reg;
  logic [N-1:0] pending_reg;
  logic [N-1:0] pending_next;
  logic         drop_reg;
  logic         drop_next;
  logic         handshake;
  logic [N-1:0] clr_mask;
  logic [W-1:0] start_sel;
  logic         found;
  logic [W-1:0] sel_idx;

  assign handshake = out_valid_reg & out_ready;

  // One-hot clear of the granted bit, only in the handshake cycle.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_clr
      assign clr_mask[gi] = handshake && (out_index_reg == W'(gi));
    end
  endgenerate

  // New requests are OR-ed in after the clear, so a same-cycle re-request
  // of the granted bit keeps it pending and is not counted as a drop.
  assign pending_next = (pending_reg & ~clr_mask) | req_in;
  assign drop_next    = |(req_in & pending_reg & ~clr_mask);

  // Search origin: one past the last grant in round-robin, else index 0.
  always_comb begin
    start_sel = '0;
    if (RR == MODE_RR) begin
      start_sel = (ptr_reg == W'(N - 1)) ? '0 : ptr_reg + W'(1);
    end
  end

  pri_find_first #(
    .N(N),
    .W(W)
  ) u_find (
    .vec  (pending_reg),
    .start(start_sel),
    .found(found),
    .idx  (sel_idx)
  );

  // Pending register and the registered drop pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_reg <= '0;
      drop_reg    <= 1'b0;
    end else begin
      pending_reg <= pending_next;
      drop_reg    <= drop_next;
    end
  end

  // Grant FSM: load a grant from IDLE, hold it in PRESENT until accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      out_valid_reg <= 1'b0;
      out_index_reg <= '0;
      ptr_reg       <= W'(N - 1);
    end else begin
      case (state_reg)
        IDLE: begin
          if (enable && found) begin
            state_reg     <= PRESENT;
            out_valid_reg <= 1'b1;
            out_index_reg <= sel_idx;
          end
        end
        PRESENT: begin
          if (out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            if (RR == MODE_RR) begin
              ptr_reg <= out_index_reg;
            end
          end
        end
      endcase
    end
  end

  assign out_valid = out_valid_reg;
  assign out_index = out_index_reg;
  assign pending   = pending_reg;
  assign drop      = drop_reg;

endmodule

// File: tb/tb_priority_encoder_q.sv
// Bench for priority_encoder_q: a fixed-priority and a round-robin instance
// share stimulus and are checked against a per-mode behavioural model.
module tb_priority_encoder_q;

  localparam int N = 16;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enable = 1'b0;
  logic         out_ready = 1'b0;
  logic [N-1:0] req_in = '0;

  logic [1:0]   d_valid;
  logic [1:0]   d_drop;
  logic [W-1:0] d_idx  [2];
  logic [N-1:0] d_pend [2];

  int checks = 0;
  int errors = 0;

  // Behavioural model state, index 0 = fixed priority, 1 = round-robin.
  logic [N-1:0] m_pend  [2];
  logic         m_valid [2];
  int           m_idx   [2];
  int           m_ptr   [2];
  logic         m_drop  [2];

  always #5 clk = ~clk;

  priority_encoder_q #(.N(N), .RR(0)) dut_fixed (
    .clk(clk), .rst(rst), .enable(enable), .req_in(req_in),
    .out_valid(d_valid[0]), .out_ready(out_ready), .out_index(d_idx[0]),
    .pending(d_pend[0]), .drop(d_drop[0])
  );

  priority_encoder_q #(.N(N), .RR(1)) dut_rr (
    .clk(clk), .rst(rst), .enable(enable), .req_in(req_in),
    .out_valid(d_valid[1]), .out_ready(out_ready), .out_index(d_idx[1]),
    .pending(d_pend[1]), .drop(d_drop[1])
  );

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_pend[m]  = '0;
      m_valid[m] = 1'b0;
      m_idx[m]   = 0;
      m_ptr[m]   = N - 1;
      m_drop[m]  = 1'b0;
    end
  endtask

  // Fixed: lowest set bit. Round-robin: first set bit after ptr, modulo N.
  function automatic int pick(int m, logic [N-1:0] p, int ptr);
    if (m == 0) begin
      for (int i = 0; i < N; i++) if (p[i]) return i;
    end else begin
      for (int k = 1; k <= N; k++) if (p[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else begin
      for (int m = 0; m < 2; m++) begin
        logic         hs;
        logic         drp;
        logic [N-1:0] np;
        hs  = m_valid[m] && out_ready;
        drp = 1'b0;
        for (int i = 0; i < N; i++)
          if (req_in[i] && m_pend[m][i] && !(hs && i == m_idx[m])) drp = 1'b1;
        np = m_pend[m];
        if (hs) np[m_idx[m]] = 1'b0;
        np = np | req_in;
        if (!m_valid[m]) begin
          if (enable && m_pend[m] != '0) begin
            m_valid[m] = 1'b1;
            m_idx[m]   = pick(m, m_pend[m], m_ptr[m]);
          end
        end else if (hs) begin
          m_valid[m] = 1'b0;
          if (m == 1) m_ptr[m] = m_idx[m];
        end
        m_pend[m] = np;
        m_drop[m] = drp;
      end
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_in = '0; enable = 1'b0; out_ready = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    cyc();
    cyc();
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (d_valid[m] !== 1'b0 || d_idx[m] !== '0 || d_pend[m] !== '0 || d_drop[m] !== 1'b0) begin
        errors++;
        $display("FAIL reset mode=%0d valid=%b idx=%0d pend=%h drop=%b required all 0",
                 m, d_valid[m], d_idx[m], d_pend[m], d_drop[m]);
      end
    end
    rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_fixed_pair();
    logic         ev [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    int           ei [5] = '{0, 4, 0, 7, 0};
    logic [N-1:0] ep [5] = '{16'h0090, 16'h0090, 16'h0080, 16'h0080, 16'h0000};
    do_reset();
    enable = 1'b1; out_ready = 1'b1; req_in = 16'h0090;
    for (int c = 0; c < 5; c++) begin
      cyc();
      req_in = '0;
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (d_valid[m] !== ev[c] || (ev[c] && d_idx[m] !== W'(ei[c])) || d_pend[m] !== ep[c]) begin
          errors++;
          $display("FAIL pair_0090 mode=%0d cycle=%0d valid=%b idx=%0d pend=%h required valid=%b idx=%0d pend=%h",
                   m, c, d_valid[m], d_idx[m], d_pend[m], ev[c], ei[c], ep[c]);
        end
      end
    end
    $display("test_fixed_pair done");
  endtask

  task automatic test_rr_hold();
    int g_rr[$];
    int g_fx[$];
    int exp_rr[4] = '{0, 15, 0, 15};
    do_reset();
    enable = 1'b1; out_ready = 1'b1; req_in = 16'h8001;
    for (int c = 0; c < 10; c++) begin
      cyc();
      if (d_valid[1] === 1'b1) g_rr.push_back(int'(d_idx[1]));
      if (d_valid[0] === 1'b1) g_fx.push_back(int'(d_idx[0]));
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (d_drop[m] !== m_drop[m] || d_pend[m] !== m_pend[m]) begin
          errors++;
          $display("FAIL rr_hold_drop mode=%0d cycle=%0d drop=%b pend=%h required drop=%b pend=%h",
                   m, c, d_drop[m], d_pend[m], m_drop[m], m_pend[m]);
        end
      end
    end
    checks++;
    if (g_rr.size() < 4) begin
      errors++;
      $display("FAIL rr_hold_count grants=%0d required>=4", g_rr.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (g_rr[k] != exp_rr[k]) begin
          errors++;
          $display("FAIL rr_hold_seq grant=%0d idx=%0d required %0d", k, g_rr[k], exp_rr[k]);
        end
      end
    end
    checks++;
    if (g_fx.size() < 4 || g_fx[0] != 0 || g_fx[3] != 0) begin
      errors++;
      $display("FAIL fixed_hold_seq grants=%0d required >=4 grants all index 0", g_fx.size());
    end
    req_in = '0;
    $display("test_rr_hold done");
  endtask

  task automatic test_backpressure();
    do_reset();
    enable = 1'b1; out_ready = 1'b0; req_in = 16'h0008;
    cyc();
    req_in = '0;
    for (int c = 0; c < 6; c++) begin
      cyc();
      enable = ~enable;
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (d_valid[m] !== 1'b1 || d_idx[m] !== 4'd3) begin
          errors++;
          $display("FAIL backpressure mode=%0d cycle=%0d valid=%b idx=%0d required valid=1 idx=3",
                   m, c, d_valid[m], d_idx[m]);
        end
      end
    end
    out_ready = 1'b1;
    cyc();
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (d_valid[m] !== 1'b0 || d_pend[m] !== '0) begin
        errors++;
        $display("FAIL backpressure_hs mode=%0d valid=%b pend=%h required valid=0 pend=0",
                 m, d_valid[m], d_pend[m]);
      end
    end
    $display("test_backpressure done");
  endtask

  task automatic test_duplicate();
    logic dexp [3] = '{1'b0, 1'b1, 1'b0};
    do_reset();
    enable = 1'b0; out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      req_in = (c < 2) ? 16'h0020 : 16'h0000;
      cyc();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (d_drop[m] !== dexp[c] || d_pend[m] !== 16'h0020 || d_valid[m] !== 1'b0) begin
          errors++;
          $display("FAIL duplicate mode=%0d cycle=%0d drop=%b pend=%h valid=%b required drop=%b pend=0020 valid=0",
                   m, c, d_drop[m], d_pend[m], d_valid[m], dexp[c]);
        end
      end
    end
    $display("test_duplicate done");
  endtask

  task automatic test_reset_mid();
    do_reset();
    enable = 1'b1; out_ready = 1'b0; req_in = 16'h0F00;
    cyc();
    req_in = '0;
    cyc();
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (d_valid[m] !== 1'b1 || d_idx[m] !== 4'd8 || d_pend[m] !== 16'h0F00) begin
        errors++;
        $display("FAIL reset_mid_setup mode=%0d valid=%b idx=%0d pend=%h required valid=1 idx=8 pend=0f00",
                 m, d_valid[m], d_idx[m], d_pend[m]);
      end
    end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (d_valid[m] !== 1'b0 || d_idx[m] !== '0 || d_pend[m] !== '0 || d_drop[m] !== 1'b0) begin
        errors++;
        $display("FAIL reset_async mode=%0d valid=%b idx=%0d pend=%h drop=%b required all 0",
                 m, d_valid[m], d_idx[m], d_pend[m], d_drop[m]);
      end
    end
    req_in = 16'h0001;
    cyc();
    rst = 1'b0;
    req_in = 16'h0050;
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (d_pend[m] !== '0) begin
        errors++;
        $display("FAIL reset_capture mode=%0d pend=%h required 0000", m, d_pend[m]);
      end
    end
    cyc();
    req_in = '0;
    cyc();
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (d_valid[m] !== 1'b1 || d_idx[m] !== 4'd4) begin
        errors++;
        $display("FAIL reset_next_grant mode=%0d valid=%b idx=%0d required valid=1 idx=4",
                 m, d_valid[m], d_idx[m]);
      end
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_wrap();
    int g[$];
    do_reset();
    enable = 1'b1; out_ready = 1'b1; req_in = 16'h4000;
    cyc();
    req_in = '0;
    cyc();
    cyc();
    checks++;
    if (m_ptr[1] != 14 || d_valid[1] !== 1'b0) begin
      errors++;
      $display("FAIL wrap_setup valid=%b model_ptr=%0d required valid=0 ptr=14", d_valid[1], m_ptr[1]);
    end
    req_in = 16'h0003;
    for (int c = 0; c < 6; c++) begin
      cyc();
      req_in = '0;
      if (d_valid[1] === 1'b1) g.push_back(int'(d_idx[1]));
    end
    checks++;
    if (g.size() != 2) begin
      errors++;
      $display("FAIL wrap_count grants=%0d required 2", g.size());
    end else begin
      checks++;
      if (g[0] != 0 || g[1] != 1) begin
        errors++;
        $display("FAIL wrap_seq got %0d,%0d required 0,1", g[0], g[1]);
      end
    end
    $display("test_wrap done");
  endtask

  task automatic test_random();
    int grants = 0;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      req_in    = ($urandom_range(0, 2) == 0) ? N'($urandom & $urandom) : '0;
      enable    = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 1) == 1);
      rst       = ($urandom_range(0, 99) == 0);
      if (m_valid[1] && out_ready && !rst) grants++;
      cyc();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (d_valid[m] !== m_valid[m] || (m_valid[m] && d_idx[m] !== W'(m_idx[m])) ||
            d_pend[m] !== m_pend[m] || d_drop[m] !== m_drop[m]) begin
          errors++;
          $display("FAIL random mode=%0d cycle=%0d valid=%b idx=%0d pend=%h drop=%b required valid=%b idx=%0d pend=%h drop=%b",
                   m, c, d_valid[m], d_idx[m], d_pend[m], d_drop[m],
                   m_valid[m], m_idx[m], m_pend[m], m_drop[m]);
        end
      end
    end
    rst = 1'b0;
    $display("test_random done, rr grants accepted=%0d", grants);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_fixed_pair();
    test_rr_hold();
    test_backpressure();
    test_duplicate();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/priority_encoder_q.md
PRIORITY_ENCODER_Q -- requirements
Module: priority_encoder_q

Interface
REQ-001 Parameter N, default 16: number of request lines; legal range 2..256.
REQ-002 Parameter W, default $clog2(N): width of the encoded index; derived from N and not overridden.
REQ-003 Parameter RR, default 0: arbitration mode; 0 = fixed priority with lowest index winning, 1 = round-robin.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port enable, input, 1 bit: grant enable; when 0, no new grant starts.
REQ-007 Port req_in, input, N bits: multi-hot request pulses, sampled every cycle.
REQ-008 Port out_valid, output, 1 bit: out_index holds a granted request.
REQ-009 Port out_ready, input, 1 bit: consumer accepts the grant.
REQ-010 Port out_index, output, W bits: binary index of the granted request; registered.
REQ-011 Port pending, output, N bits: current pending-request register.
REQ-012 Port drop, output, 1 bit: one-cycle pulse when a request hits an already-pending bit.

Function
REQ-013 Each sampled req_in[i]=1 SHALL set pending[i] at the next edge.
REQ-014 drop SHALL pulse for one cycle if any req_in[i]=1 while pending[i]=1, unless that bit is being cleared by a handshake in the same cycle.
REQ-015 The FSM SHALL have exactly two states, IDLE and PRESENT.
REQ-016 IDLE -> PRESENT when enable=1 and pending!=0; at that edge out_index loads the selected index and out_valid becomes 1.
REQ-017 Selection when RR=0: the lowest set pending bit wins.
REQ-018 Selection when RR=1: the first set bit at or after ptr+1 wins, searching upward and wrapping modulo N.
REQ-019 In PRESENT, out_valid and out_index SHALL stay stable until out_valid & out_ready, regardless of enable.
REQ-020 On handshake: pending[out_index] clears, the FSM returns to IDLE, out_valid drops at that edge, and ptr loads out_index when RR=1.
REQ-021 If req_in[out_index]=1 in the handshake cycle, the set SHALL win: the bit stays pending and drop does not pulse.
REQ-022 Latency: a request sampled at edge k, with the FSM in IDLE and enable=1, gives out_valid=1 after edge k+1.
REQ-023 Maximum throughput: one grant per 2 cycles.
REQ-024 Requests SHALL be captured while enable=0; only the IDLE->PRESENT transition is gated.
REQ-025 out_ready while out_valid=0 SHALL be ignored.

Reset
REQ-026 rst=1 SHALL immediately force: pending=0, out_valid=0, out_index=0, drop=0, FSM=IDLE, ptr=N-1.
REQ-027 Because ptr resets to N-1, the first round-robin search SHALL start at index 0.
REQ-028 Reset asserted while in PRESENT SHALL discard the outstanding grant and all pending requests.
REQ-029 No req_in is captured on the edge at which rst deasserts if rst was still high.

Structure
REQ-030 Shared package enc_pkg SHALL hold the FSM state enum (IDLE, PRESENT) and the mode constants MODE_FIXED=0 and MODE_RR=1.
REQ-031 The combinational search SHALL be one sub-module, pri_find_first.
REQ-032 pri_find_first: parameters N and W; inputs vec[N] and start[W]; outputs found (1 bit) and idx[W].
REQ-033 The fixed-priority mode SHALL drive start=0.

Verification (N=16)
REQ-034 RR=0: req_in=16'h0090 for one cycle, out_ready=1. Required: indices 4 then 7, each out_valid 2 cycles apart; pending ends 0.
REQ-035 RR=1: req_in=16'h8001 held so bits re-request every cycle, out_ready=1. Required: grant sequence 0,15,0,15; drop never pulses for the granted bit.
REQ-036 Backpressure: grant index 3, out_ready=0 for 5 cycles, enable toggled. Required: out_valid=1 and out_index=3 stable throughout; handshake on cycle 6.
REQ-037 Duplicate: pending[5]=1, not being granted, req_in=16'h0020. Required: drop=1 for exactly one cycle; pending unchanged.
REQ-038 Reset mid-grant: rst pulsed while out_valid=1 and pending=16'h0F00. Required: all outputs 0 immediately; next RR grant is the lowest index newly requested.
REQ-039 Wrap: RR=1, ptr=14, pending=16'h0003. Required: grant index 0 then index 1.
